// File: rtl/imem_fetch_responder.sv
// Instruction-memory responder: accepts one word read per handshake, answers after
// LATENCY cycles and holds the response until the fetch side takes it.
module imem_fetch_responder #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk_i_top,
  input  logic              rst_i_top,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [31:0]       req_addr_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_data_o,
  output logic              rsp_err_o,
  input  logic              ld_we_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [31:0]       ld_data_i
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam int unsigned DEPTH    = 1 << ADDR_W;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] rd_idx;
  logic [31:0]       rd_word;
  logic              addr_err;

  assign rd_idx   = req_addr_i[ADDR_W+1:2];
  assign rd_word  = mem_q[rd_idx];
  assign addr_err = (req_addr_i[1:0] != 2'b00) | (req_addr_i[31:ADDR_W+2] != '0);

  // The array is read combinationally and captured at the accept edge, while the
  // loader write lands on that same edge: a same-cycle write is therefore unseen.
  always_ff @(posedge clk_i_top) begin
    if (ld_we_i && !rst_i_top) begin
      mem_q[ld_addr_i] <= ld_data_i;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          rsp_err_d  = addr_err;
          rsp_data_d = addr_err ? '0 : rd_word;
          if (LATENCY == 1) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            cnt_d       = '0;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
        cnt_d       = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i_top) begin
    if (rst_i_top) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready_o = (state_q == ST_IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Bench for imem_fetch_responder: a LATENCY=2 and a LATENCY=1 instance sharing
// clock, reset and loader port, checked against a word-array model and scoreboard.
module tb_imem_fetch_responder;

  logic        clk;
  logic        rst;
  logic        ld_we;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;

  logic        req_valid, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, rsp_data;

  logic        req_valid_1, req_ready_1, rsp_valid_1, rsp_ready_1, rsp_err_1;
  logic [31:0] req_addr_1, rsp_data_1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [1024];
  logic [32:0] sb_q[$];
  logic [32:0] sb1_q[$];

  imem_fetch_responder #(.ADDR_W(10), .LATENCY(2)) u_dut (
    .clk_i_top  (clk),
    .rst_i_top  (rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_addr_i (req_addr),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_data_o (rsp_data),
    .rsp_err_o  (rsp_err),
    .ld_we_i    (ld_we),
    .ld_addr_i  (ld_addr),
    .ld_data_i  (ld_data)
  );

  imem_fetch_responder #(.ADDR_W(10), .LATENCY(1)) u_dut_l1 (
    .clk_i_top  (clk),
    .rst_i_top  (rst),
    .req_valid_i(req_valid_1),
    .req_ready_o(req_ready_1),
    .req_addr_i (req_addr_1),
    .rsp_valid_o(rsp_valid_1),
    .rsp_ready_i(rsp_ready_1),
    .rsp_data_o (rsp_data_1),
    .rsp_err_o  (rsp_err_1),
    .ld_we_i    (ld_we),
    .ld_addr_i  (ld_addr),
    .ld_data_i  (ld_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // {err, data} the responder must return for byte address a, from the model array
  function automatic logic [32:0] expect_rsp(input logic [31:0] a);
    logic err;
    err = (a[1:0] != 2'b00) || (a[31:12] != 20'h0);
    return {err, err ? 32'h0 : model_mem[a[11:2]]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int unsigned idx, input logic [31:0] d);
    ld_we   = 1'b1;
    ld_addr = 10'(idx);
    ld_data = d;
    model_mem[idx] = d;
    tick();
    ld_we = 1'b0;
  endtask

  task automatic test_reset();
    logic seen;
    logic [32:0] exp;
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rsp_valid); end
    n_checks++;
    if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", rsp_data); end
    n_checks++;
    if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", rsp_err); end
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    load(7, 32'h1111_7777);
    // accept a request, then reset during WAIT while the loader tries to write
    req_valid = 1'b1; req_addr = 32'h1C;
    tick();
    req_valid = 1'b0;
    rst = 1'b1; ld_we = 1'b1; ld_addr = 10'd7; ld_data = 32'hBAD0_BAD0;
    tick();
    tick();
    rst = 1'b0; ld_we = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b expected 0", rsp_valid); end
    n_checks++;
    if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL midreset_data: got %h expected 0", rsp_data); end
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b expected 1", req_ready); end
    seen = 1'b0;
    repeat (6) begin
      if (rsp_valid === 1'b1) seen = 1'b1;
      tick();
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL dropped_req_answered: got %b expected 0", seen); end
    // array survives reset and the write under reset was suppressed
    req_valid = 1'b1; req_addr = 32'h1C;
    sb_q.push_back(expect_rsp(32'h1C));
    tick();
    req_valid = 1'b0;
    tick();
    exp = sb_q.pop_front();
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, exp}) begin
      n_fail++;
      $display("FAIL post_reset_fetch: got v=%b e=%b d=%h expected v=1 e=%b d=%h",
               rsp_valid, rsp_err, rsp_data, exp[32], exp[31:0]);
    end
    tick();
  endtask

  task automatic test_basic();
    logic [32:0] exp;
    load(3, 32'h2008_0005);
    n_checks++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_T: got %b expected 1", req_ready); end
    req_valid = 1'b1; req_addr = 32'h0000_000C;
    sb_q.push_back(expect_rsp(32'hC));
    tick();
    req_valid = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_T1: got %b expected 0", rsp_valid); end
    tick();
    exp = sb_q.pop_front();
    n_checks++;
    if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_T2: got %b expected 1", rsp_valid); end
    n_checks++;
    if (rsp_data !== 32'h2008_0005 || rsp_data !== exp[31:0]) begin
      n_fail++; $display("FAIL basic_data: got %h expected 20080005", rsp_data);
    end
    n_checks++;
    if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b expected 0", rsp_err); end
    tick();
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_T3_idle: got ready=%b valid=%b expected ready=1 valid=0", req_ready, rsp_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [32:0] exp;
    logic seen;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'hC;
    sb_q.push_back(expect_rsp(32'hC));
    tick();
    req_valid = 1'b0;
    tick();
    exp = sb_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({rsp_valid, rsp_err, rsp_data, req_ready} !== {1'b1, exp, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got v=%b e=%b d=%h rdy=%b expected v=1 e=%b d=%h rdy=0",
                 i, rsp_valid, rsp_err, rsp_data, req_ready, exp[32], exp[31:0]);
      end
      req_valid = 1'b1; req_addr = 32'h1C;
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    n_checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: got ready=%b valid=%b expected ready=1 valid=0", req_ready, rsp_valid);
    end
    seen = 1'b0;
    repeat (4) begin
      if (rsp_valid === 1'b1) seen = 1'b1;
      tick();
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL bp_ignored_req: got %b expected 0", seen); end
  endtask

  task automatic test_errors();
    logic [31:0] addrs [3];
    logic [32:0] exp;
    load(1023, 32'hCAFE_F00D);
    addrs[0] = 32'h0000_0002;
    addrs[1] = 32'h0000_1000;
    addrs[2] = 32'h0000_0FFC;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid = 1'b1; req_addr = addrs[i];
      sb_q.push_back(expect_rsp(addrs[i]));
      tick();
      req_valid = 1'b0;
      tick();
      exp = sb_q.pop_front();
      n_checks++;
      if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, exp}) begin
        n_fail++;
        $display("FAIL err_addr_%h: got v=%b e=%b d=%h expected v=1 e=%b d=%h",
                 addrs[i], rsp_valid, rsp_err, rsp_data, exp[32], exp[31:0]);
      end
      tick();
    end
  endtask

  task automatic test_snapshot();
    logic [32:0] exp;
    load(0, 32'hAAAA_0001);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h0;
    sb_q.push_back(expect_rsp(32'h0));
    ld_we = 1'b1; ld_addr = 10'd0; ld_data = 32'hBBBB_0002;
    model_mem[0] = 32'hBBBB_0002;
    tick();
    req_valid = 1'b0;
    ld_data = 32'hCCCC_0003;
    model_mem[0] = 32'hCCCC_0003;
    tick();
    ld_we = 1'b0;
    exp = sb_q.pop_front();
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, exp} || rsp_data !== 32'hAAAA_0001) begin
      n_fail++; $display("FAIL snapshot_first: got v=%b d=%h expected v=1 d=aaaa0001", rsp_valid, rsp_data);
    end
    tick();
    req_valid = 1'b1; req_addr = 32'h0;
    sb_q.push_back(expect_rsp(32'h0));
    tick();
    req_valid = 1'b0;
    tick();
    exp = sb_q.pop_front();
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_data} !== {1'b1, exp} || rsp_data !== 32'hCCCC_0003) begin
      n_fail++; $display("FAIL snapshot_second: got v=%b d=%h expected v=1 d=cccc0003", rsp_valid, rsp_data);
    end
    tick();
  endtask

  task automatic test_latency1();
    logic [32:0] exp;
    load(1, 32'h1234_5678);
    rsp_ready_1 = 1'b1;
    n_checks++;
    if (req_ready_1 !== 1'b1) begin n_fail++; $display("FAIL l1_ready_T: got %b expected 1", req_ready_1); end
    req_valid_1 = 1'b1; req_addr_1 = 32'h0;
    sb1_q.push_back(expect_rsp(32'h0));
    tick();
    exp = sb1_q.pop_front();
    n_checks++;
    if ({rsp_valid_1, rsp_err_1, rsp_data_1, req_ready_1} !== {1'b1, exp, 1'b0}) begin
      n_fail++;
      $display("FAIL l1_rsp_T1: got v=%b e=%b d=%h rdy=%b expected v=1 e=%b d=%h rdy=0",
               rsp_valid_1, rsp_err_1, rsp_data_1, req_ready_1, exp[32], exp[31:0]);
    end
    req_addr_1 = 32'h4;
    tick();
    n_checks++;
    if (rsp_valid_1 !== 1'b0 || req_ready_1 !== 1'b1) begin
      n_fail++; $display("FAIL l1_idle_T2: got valid=%b ready=%b expected valid=0 ready=1", rsp_valid_1, req_ready_1);
    end
    sb1_q.push_back(expect_rsp(32'h4));
    tick();
    req_valid_1 = 1'b0;
    exp = sb1_q.pop_front();
    n_checks++;
    if ({rsp_valid_1, rsp_err_1, rsp_data_1} !== {1'b1, exp} || rsp_data_1 !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL l1_rsp_T3: got v=%b e=%b d=%h expected v=1 e=0 d=12345678", rsp_valid_1, rsp_err_1, rsp_data_1);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [6];
    logic [32:0] exp;
    int sent, got, budget;
    for (int i = 0; i < 6; i++) begin
      addrs[i] = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
      if ($urandom_range(0, 3) == 0) addrs[i][0] = 1'b1;
    end
    sent = 0; got = 0; budget = 0;
    while (got < 6 && budget < 300) begin
      rsp_ready = 1'($urandom_range(0, 1));
      req_valid = (sent < 6);
      req_addr  = (sent < 6) ? addrs[sent] : 32'h0;
      if (req_valid && req_ready) begin
        sb_q.push_back(expect_rsp(addrs[sent]));
        sent++;
      end
      if (rsp_valid === 1'b1 && rsp_ready) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++; $display("FAIL stream_unexpected_rsp: got d=%h expected no response", rsp_data);
        end else begin
          exp = sb_q.pop_front();
          if ({rsp_err, rsp_data} !== exp) begin
            n_fail++;
            $display("FAIL stream_rsp_%0d: got e=%b d=%h expected e=%b d=%h",
                     got, rsp_err, rsp_data, exp[32], exp[31:0]);
          end
        end
        got++;
      end
      tick();
      budget++;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    n_checks++;
    if (got != 6) begin n_fail++; $display("FAIL stream_timeout: got %0d responses expected 6", got); end
  endtask

  initial begin
    rst = 1'b1;
    ld_we = 1'b0; ld_addr = '0; ld_data = '0;
    req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    req_valid_1 = 1'b0; req_addr_1 = '0; rsp_ready_1 = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    for (int i = 0; i < 16; i++) load(i, $urandom);
    test_basic();
    test_backpressure();
    test_errors();
    test_snapshot();
    test_latency1();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
